// File: rtl/rcb_frl_msg_dispatch.sv
// Drains a non-FWFT 40-bit message FIFO into a 2-entry ready/valid buffer, dropping idle words.
// Optional sequence-gap checker compiled in with `define RCB_FRL_MSG_SEQCHK_EN.
module rcb_frl_msg_dispatch #(
  parameter logic [3:0] IDLE_TYPE = 4'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FIFO_EMPTY,
  input  logic [39:0] FIFO_DO,
  output logic        FIFO_RDEN,
  output logic        MSG_VALID,
  input  logic        MSG_READY,
  output logic [3:0]  MSG_TYPE,
  output logic [3:0]  MSG_SEQ,
  output logic [31:0] MSG_DATA,
  output logic        SEQ_ERR,
  output logic [15:0] DROP_CNT
);

  logic [39:0] buf_q [2];
  logic [39:0] buf_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic        start_q, start_d;
  logic [15:0] drop_q, drop_d;
  logic        pop, push, cap_idle;
  logic [1:0]  occ_after_pop;

  always_comb begin
    cap_idle      = inflight_q && (FIFO_DO[39:36] == IDLE_TYPE);
    push          = inflight_q && !cap_idle;
    pop           = (cnt_q != 2'd0) && MSG_READY;
    occ_after_pop = cnt_q - {1'b0, pop};
    // An in-flight read reserves a slot even if it turns out to be idle.
    FIFO_RDEN     = start_q && !FIFO_EMPTY &&
                    ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
    inflight_d    = FIFO_RDEN;
    start_d       = 1'b1;
    cnt_d         = cnt_q - {1'b0, pop} + {1'b0, push};
    rd_ptr_d      = rd_ptr_q ^ pop;
    wr_ptr_d      = wr_ptr_q ^ push;
    buf_d         = buf_q;
    if (push) buf_d[wr_ptr_q] = FIFO_DO;
    drop_d        = drop_q;
    if (cap_idle && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      start_q    <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      start_q    <= start_d;
      drop_q     <= drop_d;
    end
  end

  assign MSG_VALID = (cnt_q != 2'd0);
  assign MSG_TYPE  = buf_q[rd_ptr_q][39:36];
  assign MSG_SEQ   = buf_q[rd_ptr_q][35:32];
  assign MSG_DATA  = buf_q[rd_ptr_q][31:0];
  assign DROP_CNT  = drop_q;

`ifdef RCB_FRL_MSG_SEQCHK_EN
  localparam logic [0:0] SYNC_WAIT = 1'b0;
  localparam logic [0:0] LOCKED    = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic       seq_err_q, seq_err_d;

  // Every non-idle capture re-anchors the expected sequence, error or not.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    seq_err_d = 1'b0;
    if (push) begin
      exp_d   = FIFO_DO[35:32] + 4'd1;
      state_d = LOCKED;
      if ((state_q == LOCKED) && (FIFO_DO[35:32] != exp_q)) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= SYNC_WAIT;
      exp_q     <= 4'd0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign SEQ_ERR = seq_err_q;
`else
  assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rcb_frl_msg_dispatch.sv
// Directed self-checking bench for rcb_frl_msg_dispatch with a registered-output FIFO model.
module tb_rcb_frl_msg_dispatch;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        fifo_empty;
  logic [39:0] fifo_do = '0;
  logic        fifo_rden;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic [3:0]  msg_type, msg_seq;
  logic [31:0] msg_data;
  logic        seq_err;
  logic [15:0] drop_cnt;

  logic [39:0] mem [0:8191];
  logic [12:0] wr_idx = '0;
  logic [12:0] rd_idx = '0;
  logic        empty_force = 1'b0;

  logic [39:0] got [0:8191];
  logic [39:0] exp_w [0:4095];
  int          got_n = 0, rden_n = 0, viol_n = 0, err_n = 0;
  logic [3:0]  err_seq = 4'h0;
  int          chk_n = 0, pass_n = 0;

  always #5 CLK = ~CLK;

  assign fifo_empty = (rd_idx == wr_idx) || empty_force;

  rcb_frl_msg_dispatch #(.IDLE_TYPE(4'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .FIFO_EMPTY(fifo_empty), .FIFO_DO(fifo_do),
    .FIFO_RDEN(fifo_rden), .MSG_VALID(msg_valid), .MSG_READY(msg_ready),
    .MSG_TYPE(msg_type), .MSG_SEQ(msg_seq), .MSG_DATA(msg_data),
    .SEQ_ERR(seq_err), .DROP_CNT(drop_cnt)
  );

  always @(posedge CLK) begin
    if (fifo_rden) begin
      fifo_do <= mem[rd_idx];
      rd_idx  <= rd_idx + 13'd1;
    end
  end

  always @(negedge CLK) begin
    if (msg_valid && msg_ready) begin
      got[got_n[12:0]] <= {msg_type, msg_seq, msg_data};
      got_n <= got_n + 1;
    end
    if (fifo_rden) rden_n <= rden_n + 1;
    if (fifo_rden && fifo_empty) viol_n <= viol_n + 1;
    if (seq_err) begin
      err_n   <= err_n + 1;
      err_seq <= msg_seq;
    end
  end

  task automatic to_pos();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    mem[wr_idx] = {t, s, d};
    wr_idx = wr_idx + 13'd1;
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_n++; if (fifo_rden !== 1'b0) $display("FAIL reset_rden: got %b want 0", fifo_rden); else pass_n++;
    chk_n++; if (msg_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", msg_valid); else pass_n++;
    chk_n++; if (seq_err !== 1'b0) $display("FAIL reset_seq_err: got %b want 0", seq_err); else pass_n++;
    chk_n++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %h want 0", drop_cnt); else pass_n++;
    chk_n++;
    if ({msg_type, msg_seq, msg_data} !== 40'd0)
      $display("FAIL reset_msg: got %h want 0", {msg_type, msg_seq, msg_data});
    else pass_n++;
  endtask

  task automatic test_in_order();
    int base_e;
    to_pos();
    for (int i = 0; i < 6; i++) push_word(4'h1, 4'(i), 32'hA000_0000 + i);
    msg_ready = 1'b1;
    base_e = err_n;
    RST_N = 1'b1;
    @(negedge CLK);
    chk_n++; if (fifo_rden !== 1'b0) $display("FAIL first_rden_early: got %b want 0", fifo_rden); else pass_n++;
    @(negedge CLK);
    chk_n++; if (fifo_rden !== 1'b1) $display("FAIL first_rden: got %b want 1", fifo_rden); else pass_n++;
    @(negedge CLK);
    chk_n++; if (msg_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", msg_valid); else pass_n++;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk_n++;
      if ({msg_valid, msg_type, msg_seq, msg_data} !== {1'b1, 4'h1, 4'(i), 32'hA000_0000 + i})
        $display("FAIL in_order_%0d: got v=%b %h/%h/%h want v=1 1/%h/%h", i, msg_valid,
                 msg_type, msg_seq, msg_data, 4'(i), 32'hA000_0000 + i);
      else pass_n++;
    end
    @(negedge CLK);
    chk_n++; if (msg_valid !== 1'b0) $display("FAIL in_order_end: got %b want 0", msg_valid); else pass_n++;
    chk_n++; if (err_n - base_e !== 0) $display("FAIL in_order_seq_err: got %0d pulses want 0", err_n - base_e); else pass_n++;
  endtask

  task automatic test_backpressure();
    int base_g, base_r, k;
    logic unstable;
    to_pos();
    msg_ready = 1'b0;
    base_g = got_n;
    base_r = rden_n;
    for (int i = 0; i < 4; i++) push_word(4'h2, 4'(6 + i), 32'hB000_0000 + i);
    unstable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (msg_valid && ((msg_seq !== 4'd6) || (msg_data !== 32'hB000_0000))) unstable = 1'b1;
    end
    chk_n++; if (rden_n - base_r !== 2) $display("FAIL bp_reads: got %0d want 2", rden_n - base_r); else pass_n++;
    chk_n++; if (msg_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", msg_valid); else pass_n++;
    chk_n++;
    if ({msg_seq, msg_data} !== {4'd6, 32'hB000_0000})
      $display("FAIL bp_head: got %h/%h want 6/b0000000", msg_seq, msg_data);
    else pass_n++;
    chk_n++; if (unstable !== 1'b0) $display("FAIL bp_stable: got %b want 0", unstable); else pass_n++;
    chk_n++; if (got_n - base_g !== 0) $display("FAIL bp_no_pop: got %0d want 0", got_n - base_g); else pass_n++;
    to_pos();
    msg_ready = 1'b1;
    for (int c = 0; c < 8; c++) @(negedge CLK);
    chk_n++; if (got_n - base_g !== 4) $display("FAIL bp_count: got %0d want 4", got_n - base_g); else pass_n++;
    for (int i = 0; i < 4; i++) begin
      k = base_g + i;
      chk_n++;
      if (got[k[12:0]] !== {4'h2, 4'(6 + i), 32'hB000_0000 + i})
        $display("FAIL bp_word_%0d: got %h want %h", i, got[k[12:0]], {4'h2, 4'(6 + i), 32'hB000_0000 + i});
      else pass_n++;
    end
  endtask

  task automatic test_idle_drop();
    int base_g, k;
    to_pos();
    base_g = got_n;
    push_word(4'h0, 4'h0, 32'hC000_0000);
    push_word(4'h2, 4'd10, 32'hC000_0001);
    push_word(4'h0, 4'h0, 32'hC000_0002);
    push_word(4'h3, 4'd11, 32'hC000_0003);
    for (int c = 0; c < 10; c++) @(negedge CLK);
    chk_n++; if (got_n - base_g !== 2) $display("FAIL idle_count: got %0d want 2", got_n - base_g); else pass_n++;
    k = base_g;
    chk_n++;
    if (got[k[12:0]] !== {4'h2, 4'd10, 32'hC000_0001})
      $display("FAIL idle_word0: got %h want 2ac0000001", got[k[12:0]]);
    else pass_n++;
    k = base_g + 1;
    chk_n++;
    if (got[k[12:0]] !== {4'h3, 4'd11, 32'hC000_0003})
      $display("FAIL idle_word1: got %h want 3bc0000003", got[k[12:0]]);
    else pass_n++;
    chk_n++; if (drop_cnt !== 16'd2) $display("FAIL idle_drop_cnt: got %0d want 2", drop_cnt); else pass_n++;
  endtask

  task automatic test_reset_midread();
    int base_g, k;
    to_pos();
    base_g = got_n;
    push_word(4'h5, 4'h7, 32'hD000_0001);
    @(negedge CLK);
    chk_n++; if (fifo_rden !== 1'b1) $display("FAIL mid_rden: got %b want 1", fifo_rden); else pass_n++;
    to_pos();
    RST_N = 1'b0;
    @(negedge CLK);
    chk_n++;
    if ({fifo_rden, msg_valid, seq_err, drop_cnt, msg_type, msg_seq, msg_data} !== 59'd0)
      $display("FAIL mid_reset_outs: got rden=%b v=%b e=%b drop=%h msg=%h/%h/%h want all 0",
               fifo_rden, msg_valid, seq_err, drop_cnt, msg_type, msg_seq, msg_data);
    else pass_n++;
    to_pos();
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge CLK);
    chk_n++; if (got_n - base_g !== 0) $display("FAIL mid_lost_word: got %0d delivered want 0", got_n - base_g); else pass_n++;
    chk_n++; if (msg_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", msg_valid); else pass_n++;
    to_pos();
    push_word(4'h6, 4'h1, 32'hD000_0002);
    for (int c = 0; c < 6; c++) @(negedge CLK);
    chk_n++; if (got_n - base_g !== 1) $display("FAIL mid_resume_count: got %0d want 1", got_n - base_g); else pass_n++;
    k = base_g;
    chk_n++;
    if (got[k[12:0]] !== {4'h6, 4'h1, 32'hD000_0002})
      $display("FAIL mid_resume_word: got %h want 61d0000002", got[k[12:0]]);
    else pass_n++;
  endtask

  task automatic test_seq_err();
    int base_g, base_e, k;
    logic [3:0] seqs [5];
    seqs = '{4'd14, 4'd15, 4'd0, 4'd2, 4'd3};
    to_pos();
    RST_N = 1'b0;
    msg_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(4'h4, seqs[i], 32'hE000_0000 + i);
    to_pos();
    to_pos();
    base_g = got_n;
    base_e = err_n;
    RST_N = 1'b1;
    for (int c = 0; c < 12; c++) @(negedge CLK);
    chk_n++; if (got_n - base_g !== 5) $display("FAIL seq_count: got %0d want 5", got_n - base_g); else pass_n++;
    for (int i = 0; i < 5; i++) begin
      k = base_g + i;
      chk_n++;
      if (got[k[12:0]] !== {4'h4, seqs[i], 32'hE000_0000 + i})
        $display("FAIL seq_word_%0d: got %h want %h", i, got[k[12:0]], {4'h4, seqs[i], 32'hE000_0000 + i});
      else pass_n++;
    end
`ifdef RCB_FRL_MSG_SEQCHK_EN
    chk_n++; if (err_n - base_e !== 1) $display("FAIL seq_err_pulses: got %0d want 1", err_n - base_e); else pass_n++;
    chk_n++; if (err_seq !== 4'd2) $display("FAIL seq_err_at: got %h want 2", err_seq); else pass_n++;
`else
    chk_n++; if (err_n - base_e !== 0) $display("FAIL seq_err_tied: got %0d want 0", err_n - base_e); else pass_n++;
`endif
  endtask

  task automatic test_random_stream();
    int base_g, base_v, n_exp, idle_n, bad, k;
    logic [3:0]  t;
    logic [31:0] d;
    to_pos();
    base_g = got_n;
    base_v = viol_n;
    n_exp  = 0;
    idle_n = 0;
    for (int i = 0; i < 4000; i++) begin
      t = 4'($urandom_range(0, 3));
      d = $urandom;
      push_word(t, 4'(i), d);
      if (t == 4'h0) idle_n++;
      else begin
        exp_w[n_exp[11:0]] = {t, 4'(i), d};
        n_exp++;
      end
    end
    for (int c = 0; c < 10000; c++) begin
      to_pos();
      empty_force = ~empty_force;
      msg_ready = 1'($urandom_range(0, 1));
    end
    to_pos();
    empty_force = 1'b0;
    msg_ready = 1'b1;
    for (int c = 0; c < 3000 && (got_n - base_g) < n_exp; c++) @(negedge CLK);
    for (int c = 0; c < 4; c++) @(negedge CLK);
    chk_n++; if (viol_n - base_v !== 0) $display("FAIL rand_rden_empty: got %0d want 0", viol_n - base_v); else pass_n++;
    chk_n++; if (got_n - base_g !== n_exp) $display("FAIL rand_count: got %0d want %0d", got_n - base_g, n_exp); else pass_n++;
    bad = 0;
    for (int i = 0; i < n_exp && i < got_n - base_g; i++) begin
      k = base_g + i;
      if (got[k[12:0]] !== exp_w[i[11:0]]) begin
        if (bad == 0) $display("FAIL rand_word_%0d: got %h want %h", i, got[k[12:0]], exp_w[i[11:0]]);
        bad++;
      end
    end
    chk_n++; if (bad !== 0) $display("FAIL rand_stream: got %0d bad words want 0", bad); else pass_n++;
    chk_n++; if (drop_cnt !== 16'(idle_n)) $display("FAIL rand_drop: got %0d want %0d", drop_cnt, idle_n); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_idle_drop();
    test_reset_midread();
    test_seq_err();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
